// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered index/valid outputs and a one-cycle gap
// between grants. Define RR_ARB_TIMEOUT_EN to enable forced release after HOLD_MAX held cycles.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : gen_hold_max_check
    $error("rr_arbiter_4: HOLD_MAX must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [1:0] sel_idx;
  logic       sel_found;
  logic       rel_normal;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_next;
  logic       limit_hit;
  logic       tmo_q, tmo_d;
`endif

  // First set request scanning upward from the pointer, wrapping modulo 4.
  always_comb begin
    sel_idx   = ptr_q;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cand;
      cand = ptr_q + 2'(i);
      if (!sel_found && req[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    rel_normal = done | ~req[idx_q];
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    cnt_next  = cnt_q + 8'd1;
    // cnt_next counts held cycles including the current one.
    limit_hit = (cnt_next == 8'(HOLD_MAX));
`endif
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (sel_found) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          state_d = StGrant;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StGrant: begin
`ifdef RR_ARB_TIMEOUT_EN
        if (rel_normal || limit_hit) begin
          valid_d = 1'b0;
          ptr_d   = idx_q + 2'd1;
          state_d = StIdle;
          tmo_d   = ~rel_normal;
        end else begin
          cnt_d = cnt_next;
        end
`else
        if (rel_normal) begin
          valid_d = 1'b0;
          ptr_d   = idx_q + 2'd1;
          state_d = StIdle;
        end
`endif
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4; timeout checks follow RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_4 #(
    .HOLD_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] idx);
    chk({tag, "_valid"}, {3'b0, gnt_valid}, 4'd1);
    chk({tag, "_idx"}, {2'b0, gnt_idx}, {2'b0, idx});
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    chk("reset_valid", {3'b0, gnt_valid}, 4'd0);
    chk("reset_idx", {2'b0, gnt_idx}, 4'd0);
    chk("reset_timeout", {3'b0, timeout}, 4'd0);
    rst = 1'b0;

    // Asynchronous reset mid-grant, then restart from pointer 0.
    req = 4'b0001;
    step();
    chk_grant("pre_reset_grant", 2'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_drop", {3'b0, gnt_valid}, 4'd0);
    rst = 1'b0;
    step();
    chk_grant("post_reset_grant", 2'd0);
    req = 4'b0000;
    step();
    chk("drop_release", {3'b0, gnt_valid}, 4'd0);

    // Single requester held three cycles, pointer moves to 3.
    req = 4'b0100;
    step();
    chk_grant("single_c1", 2'd2);
    step();
    chk_grant("single_c2", 2'd2);
    step();
    chk_grant("single_c3", 2'd2);
    done = 1'b1;
    step();
    chk("single_release", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;
    req  = 4'b1001;
    step();
    chk_grant("ptr_after_2", 2'd3);
    done = 1'b1;
    step();
    chk("rel_3", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;

    // Fairness under full load: 0,1,2,3,0 with a gap each time.
    req = 4'b1111;
    step();
    chk_grant("fair_0", 2'd0);
    done = 1'b1;
    step();
    chk("fair_gap0", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;
    step();
    chk_grant("fair_1", 2'd1);
    done = 1'b1;
    step();
    chk("fair_gap1", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;
    step();
    chk_grant("fair_2", 2'd2);
    done = 1'b1;
    step();
    chk("fair_gap2", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;
    step();
    chk_grant("fair_3", 2'd3);
    done = 1'b1;
    step();
    chk("fair_gap3", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;
    step();
    chk_grant("fair_4", 2'd0);
    done = 1'b1;
    step();
    done = 1'b0;

    // Wrap-around: grant 3, then 0, then 1.
    req = 4'b1000;
    step();
    chk_grant("wrap_3", 2'd3);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0011;
    step();
    chk_grant("wrap_0", 2'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk_grant("wrap_1", 2'd1);
    req = 4'b0000;
    step();
    chk("wrap_release", {3'b0, gnt_valid}, 4'd0);

    // Owner drops its request; others ignored while it holds. Pointer is 2 here.
    req = 4'b0010;
    step();
    chk_grant("drop_own_1", 2'd1);
    req = 4'b1110;
    step();
    chk_grant("drop_hold_1", 2'd1);
    req = 4'b1100;
    step();
    chk("drop_release_1", {3'b0, gnt_valid}, 4'd0);
    step();
    chk_grant("drop_next_2", 2'd2);
    done = 1'b1;
    req  = 4'b0000;
    step();
    chk("idle_done_a", {3'b0, gnt_valid}, 4'd0);
    step();
    chk("idle_done_b", {3'b0, gnt_valid}, 4'd0);
    done = 1'b0;

    // Pointer is 3: req 0011 grants 0.
    req = 4'b0011;
    step();
    chk_grant("hold_0", 2'd0);
    chk("hold_tmo_c1", {3'b0, timeout}, 4'd0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_grant("tmo_hold", 2'd0);
      chk("tmo_quiet", {3'b0, timeout}, 4'd0);
    end
    step();
    chk("tmo_release", {3'b0, gnt_valid}, 4'd0);
    chk("tmo_pulse", {3'b0, timeout}, 4'd1);
    step();
    chk_grant("tmo_next_1", 2'd1);
    chk("tmo_pulse_end", {3'b0, timeout}, 4'd0);
`else
    for (int i = 0; i < 8; i++) begin
      step();
      chk_grant("no_tmo_hold", 2'd0);
      chk("no_tmo_quiet", {3'b0, timeout}, 4'd0);
    end
`endif

    req = 4'b0000;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
